pll_clk_monitor: RTL and testbench

- Single-clock frequency and lock supervisor for a PLL output clock.
- Samples the PLL output (e.g. the 8.86 MHz CPU clock) and the PLL lock signal as asynchronous data in the reference clock domain.
- Counts rising edges over a fixed gate window and compares the count against an expected value with a tolerance.
- Qualifies the clock as good after consecutive in-range windows; pulses a PLL reset request after consecutive bad windows.

---
 rtl/pll_clk_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_pll_clk_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor: frequency and lock supervisor for a PLL output clock, all logic on refclk.
// Latency: edge seen 3 refclk after meas_clk rise; results register 1 cycle after the window closes.
// Backpressure: none; count_valid is a one-cycle pulse per completed window and is not held.
//
// Ports:
//   refclk, rst        reference clock, synchronous active-high reset
//   meas_clk           monitored clock (async, must be below refclk/2)
//   pll_locked         PLL lock flag (async)
//   enable             measurement enable
//   edge_count         rising-edge count of the last completed window
//   count_valid        pulse when edge_count / freq_ok update
//   freq_ok            last completed window was within EXPECT +/- TOL
//   clk_good           qualified status after GOOD_WINDOWS in-range windows
//   pll_rst            RST_CYCLES-long reset request after BAD_WINDOWS bad windows
//   err_count          saturating count of bad windows
module pll_clk_monitor #(
    parameter int GATE_CYCLES  = 50000,
    parameter int CNT_W        = 16,
    parameter int EXPECT       = 8861,
    parameter int TOL          = 4,
    parameter int GOOD_WINDOWS = 3,
    parameter int BAD_WINDOWS  = 2,
    parameter int RST_CYCLES   = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             pll_locked,
    input  logic             enable,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic             freq_ok,
    output logic             clk_good,
    output logic             pll_rst,
    output logic [7:0]       err_count
);

    localparam int GW  = $clog2(GATE_CYCLES + 1);
    localparam int RW  = $clog2(RST_CYCLES + 1);
    localparam int GRW = $clog2(GOOD_WINDOWS + 1);
    localparam int BRW = $clog2(BAD_WINDOWS + 1);

    // Bounds widened by one bit so EXPECT+TOL cannot wrap against the counter.
    localparam logic [CNT_W:0] LO_V = (CNT_W + 1)'((EXPECT > TOL) ? (EXPECT - TOL) : 0);
    localparam logic [CNT_W:0] HI_V = (CNT_W + 1)'(EXPECT + TOL);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_EVAL, S_PLL_RST} state_t;

    state_t           state_q, state_d;
    logic             meas_s1_q, meas_s2_q, meas_s3_q;
    logic             lock_s1_q, lock_s2_q;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [GRW-1:0]   good_run_q, good_run_d;
    logic [BRW-1:0]   bad_run_q, bad_run_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [7:0]       err_q, err_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             count_valid_q, count_valid_d;
    logic             freq_ok_q, freq_ok_d;
    logic             clk_good_q, clk_good_d;
    logic             pll_rst_q, pll_rst_d;

    logic             edge_det, locked_s, gate_last, rst_last, in_range;
    logic [CNT_W:0]   cnt_x;
    logic [BRW:0]     bad_inc;
    logic [GRW:0]     good_inc;
    logic             bad_hit, good_hit;

    assign edge_det  = meas_s2_q & ~meas_s3_q;
    assign locked_s  = lock_s2_q;
    assign gate_last = (gate_q == GW'(GATE_CYCLES - 1));
    assign rst_last  = (rst_cnt_q == RW'(RST_CYCLES - 1));
    assign cnt_x     = {1'b0, edge_cnt_q};
    assign in_range  = (cnt_x >= LO_V) && (cnt_x <= HI_V);
    assign bad_inc   = {1'b0, bad_run_q} + (BRW + 1)'(1);
    assign bad_hit   = (bad_inc >= (BRW + 1)'(BAD_WINDOWS));
    assign good_inc  = {1'b0, good_run_q} + (GRW + 1)'(1);
    assign good_hit  = (good_inc >= (GRW + 1)'(GOOD_WINDOWS));

    // State and datapath registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            meas_s1_q     <= 1'b0;
            meas_s2_q     <= 1'b0;
            meas_s3_q     <= 1'b0;
            lock_s1_q     <= 1'b0;
            lock_s2_q     <= 1'b0;
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            good_run_q    <= '0;
            bad_run_q     <= '0;
            rst_cnt_q     <= '0;
            err_q         <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            freq_ok_q     <= 1'b0;
            clk_good_q    <= 1'b0;
            pll_rst_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            meas_s1_q     <= meas_clk;
            meas_s2_q     <= meas_s1_q;
            meas_s3_q     <= meas_s2_q;
            lock_s1_q     <= pll_locked;
            lock_s2_q     <= lock_s1_q;
            gate_q        <= gate_d;
            edge_cnt_q    <= edge_cnt_d;
            good_run_q    <= good_run_d;
            bad_run_q     <= bad_run_d;
            rst_cnt_q     <= rst_cnt_d;
            err_q         <= err_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
            freq_ok_q     <= freq_ok_d;
            clk_good_q    <= clk_good_d;
            pll_rst_q     <= pll_rst_d;
        end
    end

    // Next-state logic; lock loss outranks enable low inside a window
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable && locked_s) state_d = S_MEASURE;
            S_MEASURE: begin
                if (!locked_s)      state_d = bad_hit ? S_PLL_RST : S_IDLE;
                else if (!enable)   state_d = S_IDLE;
                else if (gate_last) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!in_range && bad_hit)   state_d = S_PLL_RST;
                else if (enable && locked_s) state_d = S_MEASURE;
                else                         state_d = S_IDLE;
            end
            S_PLL_RST: if (rst_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gate_d        = gate_q;
        edge_cnt_d    = edge_cnt_q;
        good_run_d    = good_run_q;
        bad_run_d     = bad_run_q;
        rst_cnt_d     = rst_cnt_q;
        err_d         = err_q;
        edge_count_d  = edge_count_q;
        count_valid_d = 1'b0;
        freq_ok_d     = freq_ok_q;
        clk_good_d    = clk_good_q;
        pll_rst_d     = (state_d == S_PLL_RST);

        case (state_q)
            S_MEASURE: begin
                if (!locked_s) begin
                    clk_good_d = 1'b0;
                    good_run_d = '0;
                    bad_run_d  = bad_inc[BRW-1:0];
                    err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                end else if (enable) begin
                    gate_d = gate_q + GW'(1);
                    // An edge on the last gate cycle still lands before EVAL reads the count
                    if (edge_det && (edge_cnt_q != {CNT_W{1'b1}}))
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                edge_count_d  = edge_cnt_q;
                count_valid_d = 1'b1;
                freq_ok_d     = in_range;
                if (in_range) begin
                    good_run_d = good_hit ? GRW'(GOOD_WINDOWS) : good_inc[GRW-1:0];
                    bad_run_d  = '0;
                    clk_good_d = good_hit;
                end else begin
                    good_run_d = '0;
                    clk_good_d = 1'b0;
                    bad_run_d  = bad_inc[BRW-1:0];
                    err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                end
            end
            S_PLL_RST: begin
                rst_cnt_d  = rst_cnt_q + RW'(1);
                bad_run_d  = '0;
                clk_good_d = 1'b0;
            end
            default: ;
        endcase

        if (state_d == S_MEASURE && state_q != S_MEASURE) begin
            gate_d     = '0;
            edge_cnt_d = '0;
        end
        if (state_d == S_PLL_RST && state_q != S_PLL_RST)
            rst_cnt_d = '0;
    end

    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;
    assign freq_ok     = freq_ok_q;
    assign clk_good    = clk_good_q;
    assign pll_rst     = pll_rst_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// tb_pll_clk_monitor: directed stimulus for pll_clk_monitor with a result scoreboard.
// Expected window results are queued ahead; a monitor pops one per count_valid pulse.
// Point checks from the stimulus thread are queued to the same monitor for counting.
module tb_pll_clk_monitor;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        meas_clk = 1'b0;
    logic        pll_locked = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] edge_count;
    logic        count_valid, freq_ok, clk_good, pll_rst;
    logic [7:0]  err_count;

    logic        meas_lvl = 1'b0;
    logic        per_en = 1'b0;
    int          per = 6;
    int          ph = 0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct packed {
        logic [15:0] cnt;
        logic        ok;
        logic        good;
        logic [7:0]  err;
    } win_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    win_t sb[$];
    chk_t cq[$];
    win_t mon_e, mon_got;
    chk_t mon_c;

    pll_clk_monitor #(
        .GATE_CYCLES(600), .CNT_W(16), .EXPECT(100), .TOL(2),
        .GOOD_WINDOWS(3), .BAD_WINDOWS(2), .RST_CYCLES(32)
    ) dut (
        .refclk(refclk), .rst(rst), .meas_clk(meas_clk), .pll_locked(pll_locked),
        .enable(enable), .edge_count(edge_count), .count_valid(count_valid),
        .freq_ok(freq_ok), .clk_good(clk_good), .pll_rst(pll_rst), .err_count(err_count)
    );

    always #5 refclk = ~refclk;

    // meas_clk source: periodic with `per` refclk cycles, or a directly driven level
    always @(negedge refclk) begin
        if (per_en) begin
            meas_clk = (ph < per / 2);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end else begin
            meas_clk = meas_lvl;
        end
    end

    // Monitor: sole owner of the comparison counters
    always @(negedge refclk) begin
        while (cq.size() > 0) begin
            mon_c = cq.pop_front();
            vec_cnt++;
            if (mon_c.act !== mon_c.exp) begin
                miss_cnt++;
                $display("FAIL %s: got %0d, want %0d", mon_c.nm, mon_c.act, mon_c.exp);
            end
        end
        if (count_valid === 1'b1) begin
            vec_cnt++;
            if (sb.size() == 0) begin
                miss_cnt++;
                $display("FAIL unexpected_count_valid: got edge_count=%0d err_count=%0d, want no window result",
                         edge_count, err_count);
            end else begin
                mon_e   = sb.pop_front();
                mon_got = {edge_count, freq_ok, clk_good, err_count};
                if (mon_got !== mon_e) begin
                    miss_cnt++;
                    $display("FAIL window_result: got cnt=%0d ok=%0b good=%0b err=%0d, want cnt=%0d ok=%0b good=%0b err=%0d",
                             mon_got.cnt, mon_got.ok, mon_got.good, mon_got.err,
                             mon_e.cnt, mon_e.ok, mon_e.good, mon_e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.nm  = nm;
        c.act = act;
        c.exp = exp;
        cq.push_back(c);
    endtask

    task automatic exp_win(input int cnt, input bit ok, input bit good, input int err);
        win_t w;
        w.cnt  = 16'(cnt);
        w.ok   = ok;
        w.good = good;
        w.err  = 8'(err);
        sb.push_back(w);
    endtask

    task automatic wait_cv(input string nm, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge refclk);
            if (count_valid) seen = 1'b1;
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_pll_rst(input string nm, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge refclk);
            if (pll_rst) seen = 1'b1;
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            meas_lvl = 1'b1;
            repeat (2) @(negedge refclk);
            meas_lvl = 1'b0;
            repeat (2) @(negedge refclk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int dir_n[3];
        dir_n[0] = 103;
        dir_n[1] = 102;
        dir_n[2] = 97;

        // Reset state
        repeat (4) @(negedge refclk);
        chk("reset_outputs", 32'({pll_rst, clk_good, freq_ok, count_valid, err_count, edge_count}), 32'd0);
        rst = 1'b0;

        // Period 6: 100 edges per 600-cycle gate, clk_good on the third result
        per = 6;
        ph = 0;
        per_en = 1'b1;
        exp_win(100, 1, 0, 0);
        exp_win(100, 1, 0, 0);
        exp_win(100, 1, 1, 0);
        repeat (3) @(negedge refclk);
        enable = 1'b1;
        wait_cv("good_win1", 700);
        wait_cv("good_win2", 700);
        wait_cv("good_win3", 700);

        // Lock lost mid-window while clk_good is set
        repeat (300) @(negedge refclk);
        chk("clk_good_before_drop", 32'(clk_good), 32'd1);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        chk("clk_good_after_drop", 32'(clk_good), 32'd0);
        chk("err_after_drop1", 32'(err_count), 32'd1);
        chk("no_pll_rst_drop1", 32'(pll_rst), 32'd0);
        repeat (7) @(negedge refclk);
        pll_locked = 1'b1;

        // Second drop in the next window escalates to a PLL reset
        repeat (300) @(negedge refclk);
        pll_locked = 1'b0;
        wait_pll_rst("pll_rst_drop2", 20);
        chk("err_after_drop2", 32'(err_count), 32'd2);

        // rst during the pulse clears everything on the next edge
        repeat (10) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        chk("rst_during_pulse", 32'({pll_rst, clk_good, freq_ok, count_valid, err_count, edge_count}), 32'd0);
        rst = 1'b0;
        pll_locked = 1'b1;

        // Period 5: 120 edges, two bad windows then a 32-cycle pll_rst
        per = 5;
        ph = 0;
        exp_win(120, 0, 0, 1);
        exp_win(120, 0, 0, 2);
        repeat (3) @(negedge refclk);
        wait_cv("fast_win1", 700);
        wait_cv("fast_win2", 700);
        enable = 1'b0;
        w = 0;
        while (pll_rst && w < 100) begin
            w++;
            @(negedge refclk);
        end
        chk("pll_rst_width", 32'(w), 32'd32);
        chk("err_after_fast", 32'(err_count), 32'd2);
        repeat (700) @(negedge refclk);
        chk("idle_no_pll_rst", 32'(pll_rst), 32'd0);

        // Directed pulse counts at the tolerance edges
        do_reset();
        per_en = 1'b0;
        meas_lvl = 1'b0;
        repeat (5) @(negedge refclk);
        exp_win(103, 0, 0, 1);
        exp_win(102, 1, 0, 1);
        exp_win(97, 0, 0, 2);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge refclk);
            pulses(dir_n[i]);
            wait_cv("directed_win", 700);
        end

        // enable low mid-window: silent abort, results unchanged
        repeat (300) @(negedge refclk);
        enable = 1'b0;
        repeat (700) @(negedge refclk);
        chk("abort_err_unchanged", 32'(err_count), 32'd2);
        chk("abort_edge_unchanged", 32'(edge_count), 32'd97);
        chk("abort_no_pll_rst", 32'(pll_rst), 32'd0);

        // meas_clk stuck high: zero edges, second bad run -> pll_rst
        meas_lvl = 1'b1;
        repeat (10) @(negedge refclk);
        exp_win(0, 0, 0, 3);
        enable = 1'b1;
        wait_cv("stuck_high_win", 2000);
        enable = 1'b0;
        chk("stuck_high_pll_rst", 32'(pll_rst), 32'd1);
        repeat (50) @(negedge refclk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
